// File: rtl/mdio_cmd_arbiter.sv
// mdio_cmd_arbiter
//   Command front end for the mdio_phy serialiser. NUM_REQ requesters post
//   MDIO register reads/writes. A round-robin arbiter picks one request at a
//   time and builds the 96-bit packet. The FSM sequences the phy handshake,
//   returns a tagged response, and then holds mdio_packet_valid low for the
//   inter-packet gap.
//
//   Optional watchdog: define MDIO_CMD_ARBITER_TIMEOUT_EN to bound the
//   STROBE/WAIT_DONE/WAIT_RD waits. A timeout answers with rsp_err=1.
//
// Ports
//   clk_8_3mhz, reset            clock, async active-high reset
//   req_valid/op/phy_addr/
//   req_reg_addr/req_wdata       packed per-requester request fields
//   req_ready                    one-hot accept pulse (combinational grant)
//   rsp_valid/id/rdata/err       single-cycle response
//   busy                         FSM not in IDLE
//   mdio_packet_data/valid,
//   rd_wr_sig                    packet interface to the phy
//   pckt_rcvd, done, read_valid,
//   read_reg_data                phy handshake / read return
//
// state     | meaning
// IDLE      | waiting for a request, grant combinationally
// SETUP     | packet + rd_wr_sig stable, count SETUP_CYC
// STROBE    | mdio_packet_valid high until pckt_rcvd
// WAIT_DONE | waiting for phy done
// WAIT_RD   | read only: waiting for read_valid
// RESP      | one-cycle response pulse
// GAP       | mdio_packet_valid held low for GAP_CYC
module mdio_cmd_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ID_W        = 1,
  parameter int SETUP_CYC   = 3,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk_8_3mhz,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_op,
  input  logic [5*NUM_REQ-1:0]  req_phy_addr,
  input  logic [5*NUM_REQ-1:0]  req_reg_addr,
  input  logic [16*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [95:0]           mdio_packet_data,
  output logic                  mdio_packet_valid,
  output logic                  rd_wr_sig,
  input  logic                  pckt_rcvd,
  input  logic                  done,
  input  logic                  read_valid,
  input  logic [15:0]           read_reg_data
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_DONE, WAIT_RD, RESP, GAP} state_e;

  localparam int CNT_MAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state_q;
  logic [ID_W-1:0]   rr_q;
  logic [ID_W-1:0]   win_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [95:0]       pkt_q;
  logic              pkt_valid_q;
  logic              rd_wr_sig_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [15:0]       rsp_rdata_q;

  // round-robin search starting at rr_q, wrapping
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic              sel_op;
  logic [4:0]        sel_phy;
  logic [4:0]        sel_reg;
  logic [15:0]       sel_wd;
  logic [95:0]       pkt_d;
  logic [ID_W-1:0]   rr_d;

  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel_op    = 1'b0;
    sel_phy   = '0;
    sel_reg   = '0;
    sel_wd    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
        sel_op    = req_op[idx];
        sel_phy   = req_phy_addr[5*idx +: 5];
        sel_reg   = req_reg_addr[5*idx +: 5];
        sel_wd    = req_wdata[16*idx +: 16];
      end
    end
    pkt_d = {64'hFFFF_FFFF_FFFF_FFFF, 2'b01,
             sel_op ? 2'b10 : 2'b01,
             sel_phy, sel_reg,
             sel_op ? 2'b11 : 2'b10,
             sel_op ? 16'hFFFF : sel_wd};
    rr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // grant is combinational so the accept pulse lands in the capture cycle
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_found && !reset)
      req_ready[gnt_idx] = 1'b1;
  end

`ifdef MDIO_CMD_ARBITER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] wd_q;
  logic            rsp_err_q;
  logic            in_wait;
  logic            wait_evt;

  assign in_wait  = (state_q == STROBE) || (state_q == WAIT_DONE) || (state_q == WAIT_RD);
  assign wait_evt = ((state_q == STROBE)    && pckt_rcvd) ||
                    ((state_q == WAIT_DONE) && done)      ||
                    ((state_q == WAIT_RD)   && read_valid);
`endif

  always_ff @(posedge clk_8_3mhz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      pkt_q       <= '0;
      pkt_valid_q <= 1'b0;
      rd_wr_sig_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
`ifdef MDIO_CMD_ARBITER_TIMEOUT_EN
      wd_q        <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (gnt_found) begin
          win_q       <= gnt_idx;
          rr_q        <= rr_d;
          rd_wr_sig_q <= sel_op;
          pkt_q       <= pkt_d;
          cnt_q       <= CNT_W'(SETUP_CYC - 1);
          state_q     <= SETUP;
        end
        SETUP: if (cnt_q == '0) begin
          pkt_valid_q <= 1'b1;
          state_q     <= STROBE;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        STROBE: if (pckt_rcvd) begin
          pkt_valid_q <= 1'b0;
          state_q     <= WAIT_DONE;
        end
        WAIT_DONE: if (done) begin
          if (rd_wr_sig_q) begin
            state_q <= WAIT_RD;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= win_q;
            rsp_rdata_q <= '0;
            state_q     <= RESP;
          end
        end
        WAIT_RD: if (read_valid) begin
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= win_q;
          rsp_rdata_q <= read_reg_data;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rd_wr_sig_q <= 1'b0;
          pkt_q       <= '0;
          cnt_q       <= CNT_W'(GAP_CYC - 1);
          state_q     <= GAP;
`ifdef MDIO_CMD_ARBITER_TIMEOUT_EN
          rsp_err_q   <= 1'b0;
`endif
        end
        GAP: if (cnt_q == '0) begin
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
`ifdef MDIO_CMD_ARBITER_TIMEOUT_EN
      // reload on any state change; a real phy event beats the timeout
      if (!in_wait || wait_evt) begin
        wd_q <= WD_W'(TIMEOUT_CYC - 1);
      end else if (wd_q == '0) begin
        pkt_valid_q <= 1'b0;
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= win_q;
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
        state_q     <= RESP;
        wd_q        <= WD_W'(TIMEOUT_CYC - 1);
      end else begin
        wd_q <= wd_q - 1'b1;
      end
`endif
    end
  end

  assign busy              = (state_q != IDLE);
  assign mdio_packet_data  = pkt_q;
  assign mdio_packet_valid = pkt_valid_q;
  assign rd_wr_sig         = rd_wr_sig_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_id            = rsp_id_q;
  assign rsp_rdata         = rsp_rdata_q;
`ifdef MDIO_CMD_ARBITER_TIMEOUT_EN
  assign rsp_err           = rsp_err_q;
`else
  assign rsp_err           = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_cmd_arbiter.sv
module tb_mdio_cmd_arbiter;
  localparam int NUM_REQ     = 2;
  localparam int ID_W        = 1;
  localparam int SETUP_CYC   = 3;
  localparam int GAP_CYC     = 4;
  localparam int TIMEOUT_CYC = 255;

  logic                  clk_8_3mhz;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_op;
  logic [5*NUM_REQ-1:0]  req_phy_addr;
  logic [5*NUM_REQ-1:0]  req_reg_addr;
  logic [16*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  busy;
  logic [95:0]           mdio_packet_data;
  logic                  mdio_packet_valid;
  logic                  rd_wr_sig;
  logic                  pckt_rcvd;
  logic                  done;
  logic                  read_valid;
  logic [15:0]           read_reg_data;

  mdio_cmd_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .SETUP_CYC(SETUP_CYC),
    .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk_8_3mhz(clk_8_3mhz), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_phy_addr(req_phy_addr),
    .req_reg_addr(req_reg_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .mdio_packet_data(mdio_packet_data),
    .mdio_packet_valid(mdio_packet_valid), .rd_wr_sig(rd_wr_sig),
    .pckt_rcvd(pckt_rcvd), .done(done), .read_valid(read_valid),
    .read_reg_data(read_reg_data)
  );

  initial clk_8_3mhz = 1'b0;
  always #5 clk_8_3mhz = ~clk_8_3mhz;

  typedef struct { logic [95:0] d; logic rw; } pkt_t;
  typedef struct { int id; logic [15:0] rdata; logic err; logic rw; } rsp_t;

  int   exp_gnt_q[$];
  pkt_t exp_pkt_q[$];
  rsp_t exp_rsp_q[$];

  int checks = 0;
  int errors = 0;
  logic        phy_no_done = 1'b0;
  logic [15:0] phy_rdata   = 16'h0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input int id, input logic op, input logic [31:0] lo,
                            input logic [15:0] rdata, input logic err, input logic want_rsp);
    pkt_t p;
    rsp_t r;
    exp_gnt_q.push_back(id);
    p.d = {64'hFFFF_FFFF_FFFF_FFFF, lo};
    p.rw = op;
    exp_pkt_q.push_back(p);
    if (want_rsp) begin
      r.id = id; r.rdata = rdata; r.err = err; r.rw = op;
      exp_rsp_q.push_back(r);
    end
  endtask

  // call at a negedge; returns at the negedge after the accept
  task automatic issue(input int i, input logic op, input logic [4:0] phy,
                       input logic [4:0] rg, input logic [15:0] wd);
    req_op[i]              = op;
    req_phy_addr[5*i +: 5] = phy;
    req_reg_addr[5*i +: 5] = rg;
    req_wdata[16*i +: 16]  = wd;
    req_valid[i]           = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      #1;
      if (req_ready[i]) begin
        @(negedge clk_8_3mhz);
        req_valid[i] = 1'b0;
        return;
      end
      @(negedge clk_8_3mhz);
    end
    chk("grant_wait_expired", 0, 1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_quiet();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_8_3mhz);
      #1;
      if (!busy && exp_gnt_q.size() == 0 && exp_pkt_q.size() == 0 && exp_rsp_q.size() == 0) begin
        @(negedge clk_8_3mhz);
        return;
      end
    end
    chk("quiet_wait_expired", 0, 1);
  endtask

  // phy model
  initial begin
    pckt_rcvd = 0; done = 0; read_valid = 0; read_reg_data = 0;
    forever begin
      @(negedge clk_8_3mhz);
      if (mdio_packet_valid && !reset) begin
        repeat (2) @(negedge clk_8_3mhz);
        pckt_rcvd = 1;
        @(negedge clk_8_3mhz);
        pckt_rcvd = 0;
        if (!phy_no_done) begin
          repeat (3) @(negedge clk_8_3mhz);
          done = 1;
          @(negedge clk_8_3mhz);
          done = 0;
          if (rd_wr_sig) begin
            repeat (2) @(negedge clk_8_3mhz);
            read_valid = 1; read_reg_data = phy_rdata;
            @(negedge clk_8_3mhz);
            read_valid = 0; read_reg_data = 16'h0;
          end
        end
      end
    end
  end

  // monitor / scoreboard
  int          cyc = 0, accept_cyc = 0, fall_cyc = 0, stable = 0;
  bit          have_fall = 0, prev_valid = 0, rw_chk = 0;
  logic [95:0] prev_data = '0;
  logic        prev_rw = 0;

  initial begin
    forever begin
      @(negedge clk_8_3mhz);
      #2;
      cyc++;
      if (!reset) begin
        if (req_ready != '0) begin
          if (exp_gnt_q.size() == 0) chk("unexpected_grant", req_ready, 0);
          else chk("grant_onehot", req_ready, NUM_REQ'(1) << exp_gnt_q.pop_front());
          accept_cyc = cyc;
        end
        if (!mdio_packet_valid) begin
          stable = (mdio_packet_data === prev_data && rd_wr_sig === prev_rw) ? stable + 1 : 1;
          if (prev_valid) begin fall_cyc = cyc; have_fall = 1; end
        end else if (!prev_valid) begin
          if (exp_pkt_q.size() == 0) chk("unexpected_packet", 1, 0);
          else begin
            pkt_t p;
            p = exp_pkt_q.pop_front();
            chk("packet_data", mdio_packet_data, p.d);
            chk("packet_rd_wr_sig", rd_wr_sig, p.rw);
            chk("strobe_latency", cyc, accept_cyc + 1 + SETUP_CYC);
            chk("setup_stable_cycles", (stable >= SETUP_CYC) ? SETUP_CYC : stable, SETUP_CYC);
            if (have_fall)
              chk("gap_low_cycles", ((cyc - fall_cyc) >= GAP_CYC) ? GAP_CYC : (cyc - fall_cyc), GAP_CYC);
          end
        end
        if (rsp_valid) begin
          if (exp_rsp_q.size() == 0) chk("unexpected_rsp", rsp_id, 0 - 1);
          else begin
            rsp_t r;
            r = exp_rsp_q.pop_front();
            chk("rsp_id", rsp_id, r.id);
            chk("rsp_rdata", rsp_rdata, r.rdata);
            chk("rsp_err", rsp_err, r.err);
            chk("rsp_rd_wr_sig", rd_wr_sig, r.rw);
            if (r.err) chk("timeout_latency", cyc - fall_cyc, TIMEOUT_CYC);
          end
          rw_chk = 1;
        end else if (rw_chk) begin
          chk("rd_wr_sig_after_resp", rd_wr_sig, 0);
          chk("rsp_valid_single_cycle", rsp_valid, 0);
          rw_chk = 0;
        end
      end
      prev_valid = mdio_packet_valid;
      prev_data  = mdio_packet_data;
      prev_rw    = rd_wr_sig;
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1; req_valid = '0; req_op = '0; req_phy_addr = '0; req_reg_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk_8_3mhz);
    req_valid[0] = 1'b1;
    #1;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pkt_valid", mdio_packet_valid, 0);
    chk("reset_pkt_data", mdio_packet_data, 0);
    chk("reset_rd_wr_sig", rd_wr_sig, 0);
    chk("reset_rsp", {rsp_valid, rsp_id, rsp_rdata, rsp_err}, 0);
    req_valid[0] = 1'b0;
    @(negedge clk_8_3mhz);
    reset = 0;
    @(negedge clk_8_3mhz);

    // single write, requester 0
    expect_txn(0, 0, 32'h5092_A5A5, 16'h0000, 0, 1);
    issue(0, 0, 5'h01, 5'h04, 16'hA5A5);
    wait_quiet();

    // single read, requester 1
    phy_rdata = 16'hBEEF;
    expect_txn(1, 1, 32'h618B_FFFF, 16'hBEEF, 0, 1);
    issue(1, 1, 5'h03, 5'h02, 16'h0000);
    wait_quiet();

    // both requesters held: grant order 0,1,0,1, back to back
    phy_rdata = 16'h1234;
    expect_txn(0, 0, 32'h5116_1111, 16'h0000, 0, 1);
    expect_txn(1, 1, 32'h621B_FFFF, 16'h1234, 0, 1);
    expect_txn(0, 0, 32'h5116_2222, 16'h0000, 0, 1);
    expect_txn(1, 1, 32'h621B_FFFF, 16'h1234, 0, 1);
    fork
      begin
        issue(0, 0, 5'h02, 5'h05, 16'h1111);
        issue(0, 0, 5'h02, 5'h05, 16'h2222);
      end
      begin
        issue(1, 1, 5'h04, 5'h06, 16'h0000);
        issue(1, 1, 5'h04, 5'h06, 16'h0000);
      end
    join
    wait_quiet();

    // reset during WAIT_DONE: no response for the aborted write
    phy_no_done = 1;
    expect_txn(0, 0, 32'h5002_0000, 16'h0000, 0, 0);
    issue(0, 0, 5'h00, 5'h00, 16'h0000);
    for (int n = 0; n < 100 && !mdio_packet_valid; n++) @(negedge clk_8_3mhz);
    for (int n = 0; n < 100 && mdio_packet_valid; n++) @(negedge clk_8_3mhz);
    chk("reached_wait_done", {busy, mdio_packet_valid}, 2'b10);
    repeat (2) @(negedge clk_8_3mhz);
    #3 reset = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_pkt", {mdio_packet_valid, mdio_packet_data}, 0);
    chk("abort_rd_wr_sig", rd_wr_sig, 0);
    chk("abort_rsp", {rsp_valid, rsp_id, rsp_rdata, rsp_err}, 0);
    repeat (2) @(negedge clk_8_3mhz);
    reset = 0;
    phy_no_done = 0;
    @(negedge clk_8_3mhz);
    expect_txn(1, 0, 32'h5FFE_FFFF, 16'h0000, 0, 1);
    issue(1, 0, 5'h1F, 5'h1F, 16'hFFFF);
    wait_quiet();

`ifdef MDIO_CMD_ARBITER_TIMEOUT_EN
    // phy never signals done: watchdog answers with rsp_err
    phy_no_done = 1;
    expect_txn(0, 1, 32'h629F_FFFF, 16'h0000, 1, 1);
    issue(0, 1, 5'h05, 5'h07, 16'h0000);
    wait_quiet();
    phy_no_done = 0;
    expect_txn(1, 0, 32'h5092_A5A5, 16'h0000, 0, 1);
    issue(1, 0, 5'h01, 5'h04, 16'hA5A5);
    wait_quiet();
`endif

    repeat (3) @(negedge clk_8_3mhz);
    chk("leftover_expectations", exp_gnt_q.size() + exp_pkt_q.size() + exp_rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
